// File: rtl/clk_en_reset_gen_pkg.sv
// Shared core definitions: the reset sequencer state encoding and the default
// divider ratios that the video timing block also depends on.
package clk_en_reset_gen_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   localparam int DEF_RST_HOLD = 1024;
   localparam int DEF_CPU_DIV  = 16;
   localparam int DEF_PIX_DIV  = 8;
   localparam int HOLD_W       = 16;

   // Width of a counter that walks 0..div-1; never narrower than one bit.
   function automatic int cnt_width(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs, cleared by an
// asynchronous active-high reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_en_reset_gen.sv
// Core reset sequencer and clock-enable generator: holds the core in reset until
// the PLL is stably locked, then emits CPU and pixel enables from one phase counter.
module clk_en_reset_gen
   import clk_en_reset_gen_pkg::*;
#(
   parameter int RST_HOLD = DEF_RST_HOLD,
   parameter int CPU_DIV  = DEF_CPU_DIV,
   parameter int PIX_DIV  = DEF_PIX_DIV
) (
   input  logic                           clk_sys,
   input  logic                           rst,
   input  logic                           pll_locked,
   input  logic                           soft_reset,
   input  logic                           pause,
   output logic                           sys_reset,
   output logic                           ce_cpu,
   output logic                           ce_cpu_n,
   output logic                           ce_pix,
   output logic [cnt_width(CPU_DIV)-1:0]  phase
);

   localparam int PH_W = cnt_width(CPU_DIV);
   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CPU_DIV - 1);
   localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(CPU_DIV / 2 - 1);
   localparam logic [PH_W-1:0]   PIX_MASK  = PH_W'(PIX_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   state_t              state, state_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic [PH_W-1:0]     phase_nxt;
   logic                lock_s;
   logic                run_nxt;
   logic                sys_reset_d, ce_cpu_d, ce_cpu_n_d, ce_pix_d;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk (clk_sys),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state     <= WAIT_LOCK;
         hold_cnt  <= '0;
         phase     <= '0;
         sys_reset <= 1'b1;
         ce_cpu    <= 1'b0;
         ce_cpu_n  <= 1'b0;
         ce_pix    <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_cnt_nxt;
         phase     <= phase_nxt;
         sys_reset <= sys_reset_d;
         ce_cpu    <= ce_cpu_d;
         ce_cpu_n  <= ce_cpu_n_d;
         ce_pix    <= ce_pix_d;
      end
   end

   // Loss of lock outranks a soft reset request in every state.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOCK: if (lock_s && !soft_reset) state_nxt = HOLD;
         HOLD: begin
            if (!lock_s)
               state_nxt = WAIT_LOCK;
            else if (!soft_reset && hold_cnt == HOLD_LAST)
               state_nxt = RUN;
         end
         RUN: begin
            if (!lock_s)
               state_nxt = WAIT_LOCK;
            else if (soft_reset)
               state_nxt = HOLD;
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   // Outputs are decoded from the next state/phase so each registered pulse
   // appears in the same cycle as the phase value it belongs to.
   always_comb begin
      hold_cnt_nxt = '0;
      phase_nxt    = '0;
      if (state == HOLD && state_nxt == HOLD && !soft_reset)
         hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      if (state == RUN && state_nxt == RUN)
         phase_nxt = phase + PH_W'(1);
      run_nxt     = (state_nxt == RUN);
      sys_reset_d = !run_nxt;
      ce_cpu_d    = run_nxt && !pause && (phase_nxt == PH_LAST);
      ce_cpu_n_d  = run_nxt && !pause && (phase_nxt == PH_HALF);
      ce_pix_d    = run_nxt && ((phase_nxt & PIX_MASK) == PIX_MASK);
   end

endmodule

// File: tb/tb_clk_en_reset_gen.sv
// Directed bench for the reset sequencer / enable generator at default parameters.
module tb_clk_en_reset_gen;
   import clk_en_reset_gen_pkg::*;

   logic       clk_sys;
   logic       rst;
   logic       pll_locked;
   logic       soft_reset;
   logic       pause;
   logic       sys_reset;
   logic       ce_cpu;
   logic       ce_cpu_n;
   logic       ce_pix;
   logic [3:0] phase;

   int errors = 0;
   int checks = 0;

   clk_en_reset_gen dut (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .pll_locked (pll_locked),
      .soft_reset (soft_reset),
      .pause      (pause),
      .sys_reset  (sys_reset),
      .ce_cpu     (ce_cpu),
      .ce_cpu_n   (ce_cpu_n),
      .ce_pix     (ce_pix),
      .phase      (phase)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // Advances to a cycle with phase==15; gives up after a bounded number of cycles.
   task automatic align_phase15(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (phase === 4'd15) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; pll_locked = 1'b0; soft_reset = 1'b0; pause = 1'b0;
      repeat (5) step();
      checks++;
      if ({sys_reset, ce_cpu, ce_cpu_n, ce_pix, phase} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_values: got %b required 10000000", {sys_reset, ce_cpu, ce_cpu_n, ce_pix, phase});
      end
      rst = 1'b0;
      step();
      checks++;
      if (sys_reset !== 1'b1 || dut.state !== WAIT_LOCK) begin
         errors++;
         $display("FAIL reset_no_lock: sys_reset=%b state=%0d required 1/WAIT_LOCK", sys_reset, dut.state);
      end
   endtask

   task automatic test_lockup();
      bit early;
      repeat (8) step();
      pll_locked = 1'b1;
      step(); step();
      checks++;
      if (dut.state !== WAIT_LOCK) begin
         errors++;
         $display("FAIL lock_sync_latency: state=%0d required WAIT_LOCK", dut.state);
      end
      step();
      checks++;
      if (dut.state !== HOLD) begin
         errors++;
         $display("FAIL hold_entry: state=%0d required HOLD", dut.state);
      end
      repeat (1023) step();
      checks++;
      if (sys_reset !== 1'b1) begin
         errors++;
         $display("FAIL hold_1023: sys_reset=%b required 1", sys_reset);
      end
      step();
      checks++;
      if (sys_reset !== 1'b0 || phase !== 4'd0) begin
         errors++;
         $display("FAIL hold_release: sys_reset=%b phase=%0d required 0/0", sys_reset, phase);
      end
      early = 1'b0;
      repeat (14) begin
         step();
         if (ce_cpu !== 1'b0) early = 1'b1;
      end
      step();
      checks++;
      if (early || ce_cpu !== 1'b1 || phase !== 4'd15) begin
         errors++;
         $display("FAIL first_ce_cpu: early=%b ce_cpu=%b phase=%0d required 0/1/15", early, ce_cpu, phase);
      end
   endtask

   task automatic test_cadence();
      int n_cpu, n_cpun, n_pix, bad_phase, b2b, bad_seq;
      logic       p_cpu, p_cpun, p_pix;
      logic [3:0] exp_ph;
      n_cpu = 0; n_cpun = 0; n_pix = 0; bad_phase = 0; b2b = 0; bad_seq = 0;
      p_cpu = ce_cpu; p_cpun = ce_cpu_n; p_pix = ce_pix;
      exp_ph = phase;
      for (int i = 0; i < 64; i++) begin
         step();
         exp_ph = exp_ph + 4'd1;
         if (phase !== exp_ph) bad_seq++;
         if (ce_cpu)   begin n_cpu++;  if (phase !== 4'd15) bad_phase++; end
         if (ce_cpu_n) begin n_cpun++; if (phase !== 4'd7)  bad_phase++; end
         if (ce_pix)   begin n_pix++;  if (phase[2:0] !== 3'd7) bad_phase++; end
         if ((ce_cpu && p_cpu) || (ce_cpu_n && p_cpun) || (ce_pix && p_pix)) b2b++;
         p_cpu = ce_cpu; p_cpun = ce_cpu_n; p_pix = ce_pix;
      end
      checks++;
      if (n_cpu !== 4) begin errors++; $display("FAIL cadence_cpu: got %0d pulses required 4", n_cpu); end
      checks++;
      if (n_cpun !== 4) begin errors++; $display("FAIL cadence_cpu_n: got %0d pulses required 4", n_cpun); end
      checks++;
      if (n_pix !== 8) begin errors++; $display("FAIL cadence_pix: got %0d pulses required 8", n_pix); end
      checks++;
      if (bad_phase !== 0 || b2b !== 0 || bad_seq !== 0) begin
         errors++;
         $display("FAIL cadence_alignment: bad_phase=%0d back_to_back=%0d bad_seq=%0d required 0/0/0", bad_phase, b2b, bad_seq);
      end
   endtask

   task automatic test_pause();
      bit found;
      int n_cpu, n_cpun, n_pix;
      align_phase15(found);
      checks++;
      if (!found) begin errors++; $display("FAIL pause_align: phase 15 not seen, phase=%0d", phase); end
      step();
      pause = 1'b1;
      n_cpu = 0; n_cpun = 0; n_pix = 0;
      for (int i = 0; i < 32; i++) begin
         n_cpu += int'(ce_cpu); n_cpun += int'(ce_cpu_n); n_pix += int'(ce_pix);
         step();
      end
      checks++;
      if (n_cpu !== 0 || n_cpun !== 0 || n_pix !== 4) begin
         errors++;
         $display("FAIL pause_held: cpu=%0d cpu_n=%0d pix=%0d required 0/0/4", n_cpu, n_cpun, n_pix);
      end
      checks++;
      if (phase !== 4'd0 || sys_reset !== 1'b0) begin
         errors++;
         $display("FAIL pause_phase: phase=%0d sys_reset=%b required 0/0", phase, sys_reset);
      end
      pause = 1'b0;
      n_cpu = 0; n_cpun = 0; n_pix = 0;
      for (int i = 0; i < 32; i++) begin
         n_cpu += int'(ce_cpu); n_cpun += int'(ce_cpu_n); n_pix += int'(ce_pix);
         step();
      end
      checks++;
      if (n_cpu !== 2 || n_cpun !== 2 || n_pix !== 4) begin
         errors++;
         $display("FAIL pause_resume: cpu=%0d cpu_n=%0d pix=%0d required 2/2/4", n_cpu, n_cpun, n_pix);
      end
   endtask

   task automatic test_soft_reset();
      soft_reset = 1'b1;
      step();
      checks++;
      if ({sys_reset, ce_cpu, ce_cpu_n, ce_pix, phase} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL soft_reset_entry: got %b required 10000000", {sys_reset, ce_cpu, ce_cpu_n, ce_pix, phase});
      end
      step(); step();
      soft_reset = 1'b0;
      repeat (1023) step();
      checks++;
      if (sys_reset !== 1'b1) begin errors++; $display("FAIL soft_hold_1023: sys_reset=%b required 1", sys_reset); end
      step();
      checks++;
      if (sys_reset !== 1'b0) begin errors++; $display("FAIL soft_hold_release: sys_reset=%b required 0", sys_reset); end
   endtask

   task automatic test_lock_loss();
      soft_reset = 1'b1;
      step();
      soft_reset = 1'b0;
      repeat (500) step();
      pll_locked = 1'b0;
      repeat (3) step();
      checks++;
      if (dut.state !== WAIT_LOCK || sys_reset !== 1'b1) begin
         errors++;
         $display("FAIL lock_loss_hold: state=%0d sys_reset=%b required WAIT_LOCK/1", dut.state, sys_reset);
      end
      repeat (3) step();
      pll_locked = 1'b1;
      repeat (1026) step();
      checks++;
      if (sys_reset !== 1'b1) begin errors++; $display("FAIL relock_1026: sys_reset=%b required 1", sys_reset); end
      step();
      checks++;
      if (sys_reset !== 1'b0) begin errors++; $display("FAIL relock_release: sys_reset=%b required 0", sys_reset); end
   endtask

   task automatic test_async_reset();
      bit found;
      align_phase15(found);
      checks++;
      if (!found || ce_cpu !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: found=%b ce_cpu=%b required 1/1", found, ce_cpu);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({sys_reset, ce_cpu, ce_cpu_n, ce_pix, phase} !== 8'b1000_0000 || dut.state !== WAIT_LOCK) begin
         errors++;
         $display("FAIL async_reset: got %b state=%0d required 10000000/WAIT_LOCK", {sys_reset, ce_cpu, ce_cpu_n, ce_pix, phase}, dut.state);
      end
      #3 rst = 1'b0;
      repeat (1026) step();
      checks++;
      if (sys_reset !== 1'b1) begin errors++; $display("FAIL async_recover_1026: sys_reset=%b required 1", sys_reset); end
      step();
      checks++;
      if (sys_reset !== 1'b0) begin errors++; $display("FAIL async_recover: sys_reset=%b required 0", sys_reset); end
   endtask

   task automatic test_priority();
      step();
      pll_locked = 1'b0;
      step(); step();
      checks++;
      if (sys_reset !== 1'b0 || dut.state !== RUN) begin
         errors++;
         $display("FAIL prio_pre: sys_reset=%b state=%0d required 0/RUN", sys_reset, dut.state);
      end
      soft_reset = 1'b1;
      step();
      checks++;
      if (dut.state !== WAIT_LOCK || sys_reset !== 1'b1 || phase !== 4'd0) begin
         errors++;
         $display("FAIL prio_lock_wins: state=%0d sys_reset=%b phase=%0d required WAIT_LOCK/1/0", dut.state, sys_reset, phase);
      end
      soft_reset = 1'b0;
      pll_locked = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_lockup();
      test_cadence();
      test_pause();
      test_soft_reset();
      test_lock_loss();
      test_async_reset();
      test_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
